fifo_fwft_reader: RTL and testbench
===================================

Name: fifo_fwft_reader

Overview:
- Read-side consumer for the team's FIFOs: drives the standard-mode FIFO read port (rd_en, rd_data, fifo_empty) in the read clock domain.
- Converts it to a first-word-fall-through valid/ready stream with a 2-entry output buffer.
- Sustains one word per cycle under full ready; never loses or duplicates a word under backpressure.
- Sits between asy_fifo's read side and any downstream stream consumer.

Parameters:
- WIDTH, 8, data word width; matches the FIFO WIDTH.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- rd_clk  in  1  read-domain clock; all logic on its rising edge.
- rd_rst  in  1  synchronous, active-high reset.
- en  in  1  when high, new FIFO reads may be issued; buffered words still drain when low.
- fifo_empty  in  1  FIFO empty flag, read domain.
- rd_en  out  1  FIFO read strobe.
- rd_data  in  WIDTH  FIFO read data, valid the cycle after an accepted rd_en.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_data  out  WIDTH  output word; head of the buffer.
- word_cnt  out  CNT_W  count of words handed downstream; wraps modulo 2^CNT_W.

Behaviour:
- Reset: one clock, rd_clk. Reset is synchronous, active-high: rd_rst sampled high at a rising edge clears all state.
  - After reset: m_valid=0, m_data=0, word_cnt=0, buffer occupancy=0, inflight=0.
  - rd_en=0 while rd_rst is high.
- FIFO latency model: rd_en high at edge N with fifo_empty=0 gives rd_data valid during cycle N+1, captured at edge N+1.
- Internal state:
  - occ, 0..2, buffer occupancy (FSM states EMPTY/ONE/TWO).
  - inflight, 1 bit; set the cycle after an issued read.
  - Buffer: head register (drives m_data) plus skid register.
- pop = m_valid && m_ready.
- Issue rule (combinational): rd_en = !rd_rst && en && !fifo_empty && (occ + inflight - pop) < 2.
  - The m_ready-to-rd_en combinational path is intentional; it gives full throughput.
- Capture: if inflight, rd_data is written to head if the head is free after pop, otherwise to skid.
  - Capacity is guaranteed by the issue rule; overflow is impossible.
- Pop: skid moves to head the same edge.
  - If skid is empty and a capture arrives, the captured word goes straight to head.
- FSM transitions, net change = capture - pop:
  - EMPTY: ->ONE on capture.
  - ONE: ->TWO on capture without pop; ->EMPTY on pop without capture; else stays.
  - TWO: ->ONE on pop; capture without pop cannot occur.
- m_valid = (occ != 0), registered.
- m_data holds stable while m_valid && !m_ready.
- word_cnt increments by 1 on each pop; wraps from 2^CNT_W-1 to 0.
- Latency: first rd_en cycle to m_valid high is 2 cycles.
- Boundary conditions:
  - fifo_empty=1: rd_en stays 0. rd_en && fifo_empty must never occur.
  - en drops mid-stream: no new reads; inflight and buffered words still delivered in order.
  - Simultaneous pop and capture with occ=1: occ stays 1 and head takes the new word.
  - Reset mid-operation: inflight and buffered words are discarded. The FIFO read side must be reset in the same cycle.

Decomposition:
- Shared package fifo_pkg: occupancy state enum (EMPTY, ONE, TWO), default WIDTH/CNT_W constants.
- One natural sub-module: fifo_skid_buf (2-entry head/skid register pair with occupancy FSM).
- Issue logic and word_cnt stay in the top module.

Test Plan:
- Reset: rd_rst high 2 cycles with fifo_empty=0, en=1 -> rd_en=0 throughout; after release m_valid=0, m_data=0, word_cnt=0.
- Streaming: FIFO preloaded with 0x11..0x18, en=1, m_ready=1 ->
  - rd_en high 8 consecutive cycles.
  - m_valid high 2 cycles after the first rd_en, for 8 consecutive cycles with data 0x11..0x18 in order.
  - word_cnt ends at 8.
- Backpressure: same preload, m_ready=0 ->
  - exactly 2 rd_en pulses, then rd_en=0.
  - m_data stable at 0x11.
  - Raise m_ready -> 0x11..0x18 delivered in order, no loss or duplicate.
- Empty: fifo_empty=1 for 20 cycles, en=1 -> rd_en never high, m_valid=0; assertion rd_en && fifo_empty never fires.
- Enable drop: en=0 after 3 reads issued with m_ready=1 -> exactly 3 words (0x11..0x13) delivered, then m_valid=0 and rd_en=0 until en=1.
- Mid-stream reset and wrap:
  - rd_rst asserted with occ=2 -> next cycle m_valid=0, word_cnt=0.
  - Separately, CNT_W=4 with 17 pops -> word_cnt=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side consumer.
// Occupancy encoding doubles as the word count held in the output buffer.
package fifo_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccTwo   = 2'd2
  } occ_e;

  function automatic logic [1:0] occ_words(occ_e occ);
    return 2'(occ);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry head/skid output buffer with occupancy FSM.
// head always presents the oldest word; skid only holds a word while head is blocked.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output occ_e             occ
);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      OccEmpty: begin
        if (cap) begin
          head_d  = cap_data;
          state_d = OccOne;
        end
      end
      OccOne: begin
        case ({cap, pop})
          2'b10: begin
            skid_d  = cap_data;
            state_d = OccTwo;
          end
          2'b01: state_d = OccEmpty;
          // Head drains and refills on the same edge.
          2'b11: head_d = cap_data;
          default: ;
        endcase
      end
      OccTwo: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = OccOne;
          if (cap) begin
            skid_d  = cap_data;
            state_d = OccTwo;
          end
        end
      end
      default: state_d = OccEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OccEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign valid = (state_q != OccEmpty);
  assign head  = head_q;
  assign occ   = state_q;

endmodule

// File: rtl/fifo_fwft_reader.sv
// Turns a standard-mode FIFO read port into a first-word-fall-through valid/ready stream.
// Reads are issued only when the buffer can absorb every word already committed.
module fifo_fwft_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] word_cnt
);

  logic             pop;
  logic             inflight_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [1:0]       committed;
  occ_e             occ;

  assign pop = m_valid && m_ready;

  // pop implies occ >= 1, so this never underflows; max value is 2.
  always_comb begin
    committed = occ_words(occ) + {1'b0, inflight_q} - {1'b0, pop};
    rd_en     = !rd_rst && en && !fifo_empty && (committed < 2'd2);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= rd_en;
      if (pop) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  fifo_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .cap     (inflight_q),
    .cap_data(rd_data),
    .pop     (pop),
    .valid   (m_valid),
    .head    (m_data),
    .occ     (occ)
  );

  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_fwft_reader.sv
// Directed bench for fifo_fwft_reader with a behavioural standard-mode FIFO feeding it.
module tb_fifo_fwft_reader;

  logic       clk = 1'b0;
  logic       rd_rst = 1'b1;
  logic       en = 1'b1;
  logic       m_ready = 1'b0;
  logic       force_empty = 1'b0;
  logic       fifo_flush = 1'b0;
  logic       fifo_empty;
  logic       rd_en, rd_en4;
  logic [7:0] rd_data = 8'h00;
  logic       m_valid, m_valid4;
  logic [7:0] m_data, m_data4;
  logic [15:0] word_cnt;
  logic [3:0]  word_cnt4;

  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         viol = 0;
  int         n_pop4 = 0;
  logic [7:0] last4 = 8'h00;
  int         rd_log[$];
  int         val_log[$];
  logic [7:0] pop_data[$];

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  fifo_fwft_reader #(
    .WIDTH(8),
    .CNT_W(16)
  ) u_dut (
    .rd_clk    (clk),
    .rd_rst    (rd_rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .word_cnt  (word_cnt)
  );

  // Narrow-counter instance sees identical stimulus; used for the wrap check.
  fifo_fwft_reader #(
    .WIDTH(8),
    .CNT_W(4)
  ) u_dut4 (
    .rd_clk    (clk),
    .rd_rst    (rd_rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .rd_en     (rd_en4),
    .rd_data   (rd_data),
    .m_valid   (m_valid4),
    .m_ready   (m_ready),
    .m_data    (m_data4),
    .word_cnt  (word_cnt4)
  );

  // FIFO read side: data appears the cycle after an accepted rd_en.
  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (rd_en && !fifo_empty) begin
      rd_data <= mem[rd_ptr % 64];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rd_en === 1'b1) rd_log.push_back(cyc);
    if (m_valid === 1'b1) val_log.push_back(cyc);
    if (m_valid === 1'b1 && m_ready === 1'b1) pop_data.push_back(m_data);
    if (m_valid4 === 1'b1 && m_ready === 1'b1) begin
      n_pop4 = n_pop4 + 1;
      last4  = m_data4;
    end
    if ((rd_en === 1'b1 || rd_en4 === 1'b1) && fifo_empty === 1'b1) viol = viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 64] = first + 8'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    val_log.delete();
    pop_data.delete();
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    fifo_flush = 1'b1;
    run_cycles(1);
    rd_rst = 1'b0;
    fifo_flush = 1'b0;
  endtask

  initial begin
    int p4;

    // Reset with a non-empty FIFO and en high: no reads may leak out.
    preload(8, 8'h11);
    clear_logs();
    run_cycles(2);
    check("rst_rd_en", rd_log.size(), 0);
    rd_rst = 1'b0;
    en = 1'b0;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_word_cnt", word_cnt, 16'd0);
    do_reset();

    // Full-rate streaming.
    preload(8, 8'h11);
    m_ready = 1'b1;
    en = 1'b1;
    clear_logs();
    run_cycles(14);
    check("stream_rd_count", rd_log.size(), 8);
    check("stream_rd_span", rd_log[7] - rd_log[0], 7);
    check("stream_val_count", val_log.size(), 8);
    check("stream_latency", val_log[0] - rd_log[0], 2);
    check("stream_val_span", val_log[7] - val_log[0], 7);
    check("stream_pops", pop_data.size(), 8);
    for (int i = 0; i < 8; i++) check("stream_data", pop_data[i], 8'h11 + 8'(i));
    check("stream_word_cnt", word_cnt, 16'd8);

    // Backpressure: two reads fill the buffer, head holds.
    do_reset();
    preload(8, 8'h11);
    m_ready = 1'b0;
    clear_logs();
    run_cycles(4);
    check("bp_m_data_early", m_data, 8'h11);
    run_cycles(6);
    check("bp_rd_count", rd_log.size(), 2);
    check("bp_m_valid", m_valid, 1'b1);
    check("bp_m_data", m_data, 8'h11);
    m_ready = 1'b1;
    run_cycles(14);
    check("bp_pops", pop_data.size(), 8);
    for (int i = 0; i < 8; i++) check("bp_data", pop_data[i], 8'h11 + 8'(i));
    check("bp_rd_total", rd_log.size(), 8);
    check("bp_word_cnt", word_cnt, 16'd8);

    // Empty FIFO: no reads, no output.
    force_empty = 1'b1;
    clear_logs();
    run_cycles(20);
    check("empty_rd", rd_log.size(), 0);
    check("empty_valid", val_log.size(), 0);
    force_empty = 1'b0;

    // Enable drop after three issued reads.
    do_reset();
    en = 1'b0;
    preload(8, 8'h11);
    m_ready = 1'b1;
    en = 1'b1;
    clear_logs();
    run_cycles(3);
    en = 1'b0;
    run_cycles(10);
    check("endrop_rd_count", rd_log.size(), 3);
    check("endrop_pops", pop_data.size(), 3);
    for (int i = 0; i < 3; i++) check("endrop_data", pop_data[i], 8'h11 + 8'(i));
    check("endrop_m_valid", m_valid, 1'b0);
    check("endrop_rd_en_low", rd_en, 1'b0);
    en = 1'b1;
    #1;
    check("endrop_rd_en_resume", rd_en, 1'b1);

    // Mid-stream reset with the buffer full.
    do_reset();
    preload(8, 8'h11);
    m_ready = 1'b1;
    en = 1'b1;
    run_cycles(5);
    m_ready = 1'b0;
    run_cycles(4);
    check("mid_m_valid", m_valid, 1'b1);
    check("mid_m_data", m_data, 8'h14);
    check("mid_word_cnt", word_cnt, 16'd3);
    do_reset();
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_word_cnt", word_cnt, 16'd0);
    check("mid_rst_m_data", m_data, 8'h00);

    // Counter wrap: 17 pops through a 4-bit counter.
    en = 1'b0;
    do_reset();
    preload(17, 8'h11);
    m_ready = 1'b1;
    p4 = n_pop4;
    en = 1'b1;
    run_cycles(25);
    check("wrap_word_cnt16", word_cnt, 16'd17);
    check("wrap_word_cnt4", word_cnt4, 4'd1);
    check("wrap_pops4", n_pop4 - p4, 17);
    check("wrap_last4", last4, 8'h21);

    check("rd_en_while_empty", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
